// File: rtl/op_move_handler.sv
// Linear-move op handler: resolves an absolute/relative XY target, clamps it to the work area,
// runs one motors burst and publishes the new position, behind a trigger/rdy/done handshake.
module op_move_handler #(
    parameter int POS_X_BITS       = 12,
    parameter int POS_Y_BITS       = 12,
    parameter int PULSE_NUM_X_BITS = 12,
    parameter int PULSE_NUM_Y_BITS = 12,
    parameter int X_MAX            = 4095,
    parameter int Y_MAX            = 4095
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clk_en,
    input  logic                        trigger,
    input  logic                        rel_mode,
    input  logic [POS_X_BITS:0]         arg_x,
    input  logic [POS_Y_BITS:0]         arg_y,
    output logic                        rdy,
    output logic                        done,
    input  logic [POS_X_BITS-1:0]       cur_x,
    input  logic [POS_Y_BITS-1:0]       cur_y,
    input  logic                        motors_rdy,
    input  logic                        motors_done,
    output logic                        motors_trigger,
    output logic [PULSE_NUM_X_BITS-1:0] motors_pulse_x,
    output logic [PULSE_NUM_Y_BITS-1:0] motors_pulse_y,
    output logic                        motors_dir_x,
    output logic                        motors_dir_y,
    output logic [POS_X_BITS-1:0]       pos_new_x,
    output logic [POS_Y_BITS-1:0]       pos_new_y,
    output logic                        pos_update,
    output logic [2:0]                  fsm_state
);
    // Handshake: an op is accepted on an enabled edge where rdy=1 and trigger=1; done marks its end.
    localparam int XW = POS_X_BITS + 2;
    localparam int YW = POS_Y_BITS + 2;
    localparam logic signed [XW-1:0] X_MAX_S = XW'(X_MAX);
    localparam logic signed [YW-1:0] Y_MAX_S = YW'(Y_MAX);
    localparam logic [31:0] PX_MAX = (32'd1 << PULSE_NUM_X_BITS) - 32'd1;
    localparam logic [31:0] PY_MAX = (32'd1 << PULSE_NUM_Y_BITS) - 32'd1;

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_WAIT_MRDY, S_START, S_WAIT_MDONE, S_UPDATE, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic                  rel_q;
    logic [POS_X_BITS:0]   arg_x_q;
    logic [POS_Y_BITS:0]   arg_y_q;
    logic [POS_X_BITS-1:0] cur_x_q, tgt_x_q;
    logic [POS_Y_BITS-1:0] cur_y_q, tgt_y_q;

    logic signed [XW-1:0]  cur_x_e, arg_x_e, sum_x, tgt_x_s, delta_x;
    logic signed [YW-1:0]  cur_y_e, arg_y_e, sum_y, tgt_y_s, delta_y;
    logic [XW-1:0]         abs_x;
    logic [YW-1:0]         abs_y;
    logic [31:0]           abs_x32, abs_y32;
    logic [PULSE_NUM_X_BITS-1:0] pulse_x_c;
    logic [PULSE_NUM_Y_BITS-1:0] pulse_y_c;
    logic                  zero_move;

    // Target arithmetic runs two bits wider than the position so cur+arg never wraps.
    assign cur_x_e = $signed({2'b00, cur_x_q});
    assign cur_y_e = $signed({2'b00, cur_y_q});
    assign arg_x_e = $signed({arg_x_q[POS_X_BITS], arg_x_q});
    assign arg_y_e = $signed({arg_y_q[POS_Y_BITS], arg_y_q});
    assign sum_x   = rel_q ? cur_x_e + arg_x_e : arg_x_e;
    assign sum_y   = rel_q ? cur_y_e + arg_y_e : arg_y_e;

    always_comb begin
        tgt_x_s = sum_x;
        tgt_y_s = sum_y;
        if (sum_x[XW-1])          tgt_x_s = '0;
        else if (sum_x > X_MAX_S) tgt_x_s = X_MAX_S;
        if (sum_y[YW-1])          tgt_y_s = '0;
        else if (sum_y > Y_MAX_S) tgt_y_s = Y_MAX_S;
    end

    assign delta_x   = tgt_x_s - cur_x_e;
    assign delta_y   = tgt_y_s - cur_y_e;
    assign abs_x     = delta_x[XW-1] ? $unsigned(-delta_x) : $unsigned(delta_x);
    assign abs_y     = delta_y[YW-1] ? $unsigned(-delta_y) : $unsigned(delta_y);
    assign abs_x32   = 32'(abs_x);
    assign abs_y32   = 32'(abs_y);
    assign pulse_x_c = (abs_x32 > PX_MAX) ? PULSE_NUM_X_BITS'(PX_MAX) : PULSE_NUM_X_BITS'(abs_x32);
    assign pulse_y_c = (abs_y32 > PY_MAX) ? PULSE_NUM_Y_BITS'(PY_MAX) : PULSE_NUM_Y_BITS'(abs_y32);
    assign zero_move = (delta_x == '0) && (delta_y == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      state <= S_IDLE;
        else if (clk_en) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (trigger) state_nxt = S_CALC;
            S_CALC:       state_nxt = zero_move ? S_UPDATE : S_WAIT_MRDY;
            S_WAIT_MRDY:  if (motors_rdy) state_nxt = S_START;
            S_START:      state_nxt = S_WAIT_MDONE;
            S_WAIT_MDONE: if (motors_done) state_nxt = S_UPDATE;
            S_UPDATE:     state_nxt = S_DONE;
            S_DONE:       state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    assign rdy       = (state == S_IDLE);
    assign fsm_state = state;

    // Strobes are registered from the current state, so each lasts exactly one enabled cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rel_q          <= 1'b0;
            arg_x_q        <= '0;
            arg_y_q        <= '0;
            cur_x_q        <= '0;
            cur_y_q        <= '0;
            tgt_x_q        <= '0;
            tgt_y_q        <= '0;
            motors_pulse_x <= '0;
            motors_pulse_y <= '0;
            motors_dir_x   <= 1'b0;
            motors_dir_y   <= 1'b0;
            motors_trigger <= 1'b0;
            pos_update     <= 1'b0;
            pos_new_x      <= '0;
            pos_new_y      <= '0;
            done           <= 1'b0;
        end else if (clk_en) begin
            if (state == S_IDLE && trigger) begin
                rel_q   <= rel_mode;
                arg_x_q <= arg_x;
                arg_y_q <= arg_y;
                cur_x_q <= cur_x;
                cur_y_q <= cur_y;
            end
            if (state == S_CALC) begin
                tgt_x_q        <= POS_X_BITS'(tgt_x_s);
                tgt_y_q        <= POS_Y_BITS'(tgt_y_s);
                motors_pulse_x <= pulse_x_c;
                motors_pulse_y <= pulse_y_c;
                motors_dir_x   <= delta_x[XW-1];
                motors_dir_y   <= delta_y[YW-1];
            end
            if (state == S_UPDATE) begin
                pos_new_x <= tgt_x_q;
                pos_new_y <= tgt_y_q;
            end
            motors_trigger <= (state == S_START);
            pos_update     <= (state == S_UPDATE);
            done           <= (state == S_DONE);
        end
    end
endmodule

// File: tb/tb_op_move_handler.sv
// Randomised scoreboard bench for op_move_handler: a behavioural target/clamp model queues the
// expected motors_trigger / pos_update / done events; a monitor pops and compares them.
module tb_op_move_handler;
    localparam int PMAX = 4095;

    typedef enum logic [1:0] { K_MT = 2'd0, K_PU = 2'd1, K_DONE = 2'd2 } kind_t;
    typedef struct packed {
        kind_t       kind;
        logic [11:0] a;
        logic [11:0] b;
        logic        da;
        logic        db;
        logic        chk_lat;
    } exp_t;

    exp_t exp_q[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_en = 1'b1;
    logic        trigger = 1'b0;
    logic        rel_mode = 1'b0;
    logic [12:0] arg_x = '0;
    logic [12:0] arg_y = '0;
    logic        rdy, done;
    logic [11:0] cur_x = '0;
    logic [11:0] cur_y = '0;
    logic        motors_rdy = 1'b1;
    logic        motors_done = 1'b0;
    logic        motors_trigger;
    logic [11:0] motors_pulse_x, motors_pulse_y;
    logic        motors_dir_x, motors_dir_y;
    logic [11:0] pos_new_x, pos_new_y;
    logic        pos_update;
    logic [2:0]  fsm_state;

    int  n_checks = 0;
    int  n_pass = 0;
    int  n_done = 0;
    int  n_mt = 0;
    int  ecyc = 0;
    int  trig_cyc = 0;
    int  mdone_cyc = 0;
    bit  en_last = 1'b0;
    bit  toggle_en = 1'b0;
    bit  m_block = 1'b0;

    op_move_handler dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .trigger(trigger), .rel_mode(rel_mode),
        .arg_x(arg_x), .arg_y(arg_y), .rdy(rdy), .done(done), .cur_x(cur_x), .cur_y(cur_y),
        .motors_rdy(motors_rdy), .motors_done(motors_done), .motors_trigger(motors_trigger),
        .motors_pulse_x(motors_pulse_x), .motors_pulse_y(motors_pulse_y),
        .motors_dir_x(motors_dir_x), .motors_dir_y(motors_dir_y),
        .pos_new_x(pos_new_x), .pos_new_y(pos_new_y), .pos_update(pos_update),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / enable ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        en_last <= clk_en;
        if (clk_en) ecyc <= ecyc + 1;
    end

    initial forever begin
        @(negedge clk);
        clk_en = toggle_en ? ~clk_en : 1'b1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    task automatic wait_en_edge();
        @(negedge clk);
        while (!en_last) @(negedge clk);
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // ---------------- motors controller model ----------------
    initial forever begin
        @(negedge clk);
        if (en_last && motors_trigger && !m_block) begin
            int d;
            d = $urandom_range(0, 5);
            repeat (d) wait_en_edge();
            motors_done = 1'b1;
            wait_en_edge();
            mdone_cyc = ecyc;
            motors_done = 1'b0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial forever begin
        @(negedge clk);
        if (en_last && reset) begin
            if (motors_trigger) begin
                n_mt++;
                if (exp_q.size() == 0) check("unexpected_motors_trigger", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("mt_kind", int'(K_MT), int'(e.kind));
                    check("pulse_x", motors_pulse_x, e.a);
                    check("pulse_y", motors_pulse_y, e.b);
                    check("dir_x", motors_dir_x, e.da);
                    check("dir_y", motors_dir_y, e.db);
                    if (e.chk_lat) check("trigger_to_mt_latency", ecyc - trig_cyc, 3);
                end
            end
            if (pos_update) begin
                if (exp_q.size() == 0) check("unexpected_pos_update", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pu_kind", int'(K_PU), int'(e.kind));
                    check("pos_new_x", pos_new_x, e.a);
                    check("pos_new_y", pos_new_y, e.b);
                end
            end
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_kind", int'(K_DONE), int'(e.kind));
                    if (e.da) check("zero_move_trigger_to_done", ecyc - trig_cyc, 3);
                    else      check("mdone_to_done_latency", ecyc - mdone_cyc, 2);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic push_model(input bit rel, input int ax, input int ay, input int cx,
                              input int cy, input bit stall, input bit mt_only);
        int tx, ty, dx, dy;
        exp_t e;
        tx = clampi(rel ? cx + ax : ax, 4095);
        ty = clampi(rel ? cy + ay : ay, 4095);
        dx = tx - cx;
        dy = ty - cy;
        if (dx != 0 || dy != 0) begin
            e.kind = K_MT;
            e.a = 12'(clampi(dx < 0 ? -dx : dx, PMAX));
            e.b = 12'(clampi(dy < 0 ? -dy : dy, PMAX));
            e.da = (dx < 0);
            e.db = (dy < 0);
            e.chk_lat = !stall;
            exp_q.push_back(e);
        end
        if (!mt_only) begin
            e = '0;
            e.kind = K_PU;
            e.a = 12'(tx);
            e.b = 12'(ty);
            exp_q.push_back(e);
            e = '0;
            e.kind = K_DONE;
            e.da = (dx == 0 && dy == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_rdy();
        int t;
        t = 0;
        @(negedge clk);
        while (!rdy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!rdy) check("rdy_timeout", 0, 1);
    endtask

    task automatic start_op(input bit rel, input int ax, input int ay, input int cx, input int cy);
        rel_mode = rel;
        arg_x = 13'(ax);
        arg_y = 13'(ay);
        cur_x = 12'(cx);
        cur_y = 12'(cy);
        trigger = 1'b1;
        wait_en_edge();
        trig_cyc = ecyc;
        trigger = 1'b0;
        // Scramble the sampled inputs so a missing latch shows up in the results.
        rel_mode = 1'($urandom_range(0, 1));
        arg_x = 13'($urandom);
        arg_y = 13'($urandom);
        cur_x = 12'($urandom);
        cur_y = 12'($urandom);
    endtask

    task automatic do_op(input bit rel, input int ax, input int ay, input int cx, input int cy,
                         input bit stall);
        int n0, mt0, t;
        wait_rdy();
        push_model(rel, ax, ay, cx, cy, stall, 1'b0);
        n0 = n_done;
        if (stall) motors_rdy = 1'b0;
        start_op(rel, ax, ay, cx, cy);
        if (stall) begin
            mt0 = n_mt;
            repeat (20) begin
                wait_en_edge();
                trigger = 1'($urandom_range(0, 1));
            end
            trigger = 1'b0;
            check("mt_waits_for_motors_rdy", n_mt - mt0, 0);
            motors_rdy = 1'b1;
        end
        t = 0;
        while (n_done == n0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (n_done == n0) check("done_timeout", 0, 1);
        repeat (4) wait_en_edge();
        check("exactly_one_done", n_done - n0, 1);
    endtask

    task automatic reset_mid_op();
        int t, mt0;
        wait_rdy();
        m_block = 1'b1;
        push_model(1'b0, 500, 600, 100, 100, 1'b0, 1'b1);
        mt0 = n_mt;
        start_op(1'b0, 500, 600, 100, 100);
        t = 0;
        while (n_mt == mt0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("reset_test_mt_seen", n_mt - mt0, 1);
        repeat (3) wait_en_edge();
        reset = 1'b0;
        #1;
        check("abort_rdy", rdy, 1);
        check("abort_done", done, 0);
        check("abort_pos_update", pos_update, 0);
        check("abort_motors_trigger", motors_trigger, 0);
        @(posedge clk);
        #1;
        check("abort_rdy_next_edge", rdy, 1);
        check("abort_done_next_edge", done, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        m_block = 1'b0;
        repeat (10) wait_en_edge();
        check("abort_no_late_events", exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        check("reset_rdy", rdy, 1);
        check("reset_done", done, 0);
        check("reset_motors_trigger", motors_trigger, 0);
        check("reset_pos_update", pos_update, 0);
        check("reset_pulse_x", motors_pulse_x, 0);
        check("reset_pos_new_y", pos_new_y, 0);
        reset = 1'b1;

        do_op(1'b0, 300, 50, 100, 200, 1'b0);     // absolute move
        do_op(1'b1, -30, 4095, 10, 10, 1'b0);     // relative move clamped both ways
        do_op(1'b0, 777, 888, 777, 888, 1'b0);    // zero move
        do_op(1'b1, 0, 0, 1234, 42, 1'b0);        // relative zero move
        do_op(1'b0, -4096, 4095, 4095, 0, 1'b0);  // full-range sweep
        do_op(1'b1, 250, -300, 600, 700, 1'b1);   // motors busy, triggers ignored
        toggle_en = 1'b1;
        do_op(1'b0, 300, 50, 100, 200, 1'b0);     // gated clock enable
        toggle_en = 1'b0;
        reset_mid_op();

        for (int i = 0; i < 40; i++) begin
            int ax, ay, cx, cy;
            bit rel;
            rel = 1'($urandom_range(0, 1));
            cx = $urandom_range(0, 4095);
            cy = $urandom_range(0, 4095);
            ax = (i % 7 == 3 && !rel) ? cx : $urandom_range(0, 8191) - 4096;
            ay = (i % 7 == 3 && !rel) ? cy : $urandom_range(0, 8191) - 4096;
            toggle_en = 1'($urandom_range(0, 1));
            do_op(rel, ax, ay, cx, cy, 1'($urandom_range(0, 9) == 0));
        end
        toggle_en = 1'b0;
        repeat (5) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
